regfile_writeback: RTL

//  Write-back sequencer that drives the write port (RegWrite/write_register/write_data) of the
//  32x32 MIPS register file. Merges a single-cycle ALU result stream with a buffered memory/

---
 rtl/regfile_writeback_pkg.sv | 21 ++
 rtl/regfile_writeback_if.sv | 25 ++
 rtl/regfile_writeback_fifo.sv | 70 +++++++
 rtl/regfile_writeback.sv | 120 ++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared types for the MIPS write-back sequencer: data/index widths,
// the queued write-back entry and the output-source select.
package mips_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MEM
    } wb_sel_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Memory/long-latency result handshake (valid/ready) into the write-back
// queue. master: result producer. slave: write-back sequencer.
interface regfile_writeback_if;
    import mips_pkg::*;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;

    modport master (
        output mem_valid,
        output mem_rd,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_rd,
        input  mem_data,
        output mem_ready
    );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: wrap-around FIFO of write-back entries with squash-by-rd.
// Ports: push/push_entry, pop, flush, squash_en/squash_rd, head, count,
// full, empty. No fall-through: a pushed entry is visible at head only
// after the edge that stored it.
module wb_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    input  logic          flush,
    input  logic          squash_en,
    input  logic [AW-1:0] squash_rd,
    output wb_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_entry_t     slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign head = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Squashing free slots is harmless; the push write lands last so
    // the incoming entry keeps the valid bit computed by the caller.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && slots[i].rd == squash_rd)
                slots[i].valid <= 1'b0;
        end
        if (do_push)
            slots[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: drives the register-file write port from the ALU
// stream (priority) and a queued memory-result stream. Ports: clk, rst
// (async, active-low), alu_valid/alu_rd/alu_data, mem (slave handshake),
// flush, RegWrite/write_register/write_data (registered), q_count.
// Macro WB_FORWARD_EN adds fwd_reg/fwd_hit/fwd_data bypass ports.
module regfile_writeback
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [AW-1:0]       alu_rd,
    input  logic [DW-1:0]       alu_data,
    regfile_writeback_if.slave  mem,
    input  logic                flush,
    output logic                RegWrite,
    output logic [AW-1:0]       write_register,
    output logic [DW-1:0]       write_data,
    output logic [CW-1:0]       q_count
`ifdef WB_FORWARD_EN
    ,
    input  logic [AW-1:0]       fwd_reg,
    output logic                fwd_hit,
    output logic [DW-1:0]       fwd_data
`endif
);

    logic      alu_wr;
    logic      xfer;
    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    wb_entry_t head;
    wb_entry_t push_entry;
    wb_sel_e   sel;

    assign alu_wr = alu_valid & (alu_rd != REG_ZERO);

    // Held low during reset; otherwise a pure function of occupancy.
    assign mem.mem_ready = rst & ~full;
    assign xfer          = mem.mem_valid & mem.mem_ready;

    // Writes to $0 complete the handshake but never occupy a slot.
    assign push = xfer & (mem.mem_rd != REG_ZERO);

    // The ALU write is younger than a same-cycle memory result to the
    // same register, so that result enters the queue already dead.
    always_comb begin
        push_entry       = '0;
        push_entry.valid = ~(alu_wr & (mem.mem_rd == alu_rd));
        push_entry.rd    = mem.mem_rd;
        push_entry.data  = mem.mem_data;
    end

    always_comb begin
        sel = SEL_NONE;
        if (alu_wr)
            sel = SEL_ALU;
        else if (!empty && !flush)
            sel = SEL_MEM;
    end

    assign pop = (sel == SEL_MEM);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .squash_en  (alu_wr),
        .squash_rd  (alu_rd),
        .head       (head),
        .count      (q_count),
        .full       (full),
        .empty      (empty)
    );

    // Index/data hold their last value whenever no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            unique case (sel)
                SEL_ALU: begin
                    RegWrite       <= 1'b1;
                    write_register <= alu_rd;
                    write_data     <= alu_data;
                end
                SEL_MEM: begin
                    RegWrite <= head.valid;
                    if (head.valid) begin
                        write_register <= head.rd;
                        write_data     <= head.data;
                    end
                end
                default: begin
                    RegWrite <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Bypass of the value the register file commits at the next edge.
    assign fwd_hit  = RegWrite & (write_register == fwd_reg)
                      & (fwd_reg != REG_ZERO);
    assign fwd_data = fwd_hit ? write_data : '0;
`endif

endmodule
